// File: rtl/spi_fpga_slave.sv
// SPI slave for all four CPOL/CPHA modes, clocked only by the master's SCLK.
// Shifts a PACK_LENGTH-bit word out on MISO and assembles MOSI into OUT_RECEIVE_DATA.
module spi_fpga_slave #(
  parameter int CPHA                       = 1,
  parameter int CPOL                       = 1,
  parameter int PACK_LENGTH                = 8,
  parameter int PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int PACK_BIT_SEQUENCE_RECEIVE  = 1
) (
  input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
  input  logic                   MOSI,
  input  logic                   CS,
  input  logic                   SCLK,
  input  logic                   IN_RESET,
  output logic                   MISO,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA
);

  localparam int              CW       = $clog2(PACK_LENGTH);
  localparam logic [CW-1:0]   LAST     = CW'(PACK_LENGTH - 1);
  localparam logic            EDGE_INV = (CPOL != CPHA);
  localparam logic            TX_MSB   = (PACK_BIT_SEQUENCE_TRANSMIT != 0);
  localparam logic            RX_MSB   = (PACK_BIT_SEQUENCE_RECEIVE != 0);

  // Rising edge of sample_clk is the sample edge; its falling edge is the shift edge.
  logic sample_clk;
  logic frame_clr;
  assign sample_clk = SCLK ^ EDGE_INV;
  assign frame_clr  = IN_RESET | CS;

  logic [CW-1:0]          bit_cnt;
  logic [CW-1:0]          tx_idx;
  logic [CW-1:0]          tx_sel;
  logic [PACK_LENGTH-1:0] rx_shift;
  logic [PACK_LENGTH-1:0] rx_next;
  logic [PACK_LENGTH-1:0] tx_word;
  logic                   tx_bit;

  // NOTE: every combinational output is assigned on every path, so no latch is inferred.
  always_comb begin
    rx_next = RX_MSB ? {rx_shift[PACK_LENGTH-2:0], MOSI}
                     : {MOSI, rx_shift[PACK_LENGTH-1:1]};
    tx_sel  = TX_MSB ? LAST - tx_idx : tx_idx;
    // With CPHA=0 the first bit must be visible before any SCLK edge, so it comes straight from the input.
    tx_bit  = (CPHA == 0 && tx_idx == '0) ? IN_TRANSMIT_DATA[tx_sel] : tx_word[tx_sel];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sample_clk or posedge frame_clr) begin
    if (frame_clr) bit_cnt <= '0;
    else           bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
  end

  always_ff @(posedge sample_clk or posedge IN_RESET) begin
    if (IN_RESET) begin
      rx_shift         <= '0;
      OUT_RECEIVE_DATA <= '0;
    end else if (!CS) begin
      rx_shift <= rx_next;
      if (bit_cnt == LAST) OUT_RECEIVE_DATA <= rx_next;
    end
  end

  // The MISO bit index follows the sample count one shift edge later.
  always_ff @(negedge sample_clk or posedge frame_clr) begin
    if (frame_clr) tx_idx <= '0;
    else           tx_idx <= bit_cnt;
  end

  // The transmit word is captured on the first edge of each packet that the master clocks.
  generate
    if (CPHA == 0) begin : g_load_on_sample
      always_ff @(posedge sample_clk or posedge IN_RESET) begin
        if (IN_RESET)                   tx_word <= '0;
        else if (!CS && bit_cnt == '0)  tx_word <= IN_TRANSMIT_DATA;
      end
    end else begin : g_load_on_shift
      always_ff @(negedge sample_clk or posedge IN_RESET) begin
        if (IN_RESET)                   tx_word <= '0;
        else if (!CS && bit_cnt == '0)  tx_word <= IN_TRANSMIT_DATA;
      end
    end
  endgenerate

  assign MISO = CS ? 1'bz : (IN_RESET ? 1'b0 : tx_bit);

endmodule

// File: tb/tb_spi_fpga_slave.sv
// Self-checking bench: four slaves (one per SPI mode, mixed bit orders) share one bit-banged master.
// Expected words come from a packet-level model: master reads back the TX word, RX word is the bit stream in order.
module tb_spi_fpga_slave;

  // Instance k: 0 = mode 0 LSB/LSB, 1 = mode 1 MSB/LSB, 2 = mode 2 LSB/MSB, 3 = mode 3 MSB/MSB (tx/rx order).
  localparam logic [3:0] TX_MSB = 4'b1010;
  localparam logic [3:0] RX_MSB = 4'b1100;

  logic       pclk;   // master phase clock: leading edge is always its rising edge
  logic       cs;
  logic       mosi;
  logic       rst;
  logic [7:0] txd;
  wire        miso0, miso1, miso2, miso3;
  wire  [7:0] out0, out1, out2, out3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_out [4];

  spi_fpga_slave #(.CPHA(0), .CPOL(0), .PACK_LENGTH(8),
                   .PACK_BIT_SEQUENCE_TRANSMIT(0), .PACK_BIT_SEQUENCE_RECEIVE(0)) u0 (
    .IN_TRANSMIT_DATA(txd), .MOSI(mosi), .CS(cs), .SCLK(pclk), .IN_RESET(rst),
    .MISO(miso0), .OUT_RECEIVE_DATA(out0));
  spi_fpga_slave #(.CPHA(1), .CPOL(0), .PACK_LENGTH(8),
                   .PACK_BIT_SEQUENCE_TRANSMIT(1), .PACK_BIT_SEQUENCE_RECEIVE(0)) u1 (
    .IN_TRANSMIT_DATA(txd), .MOSI(mosi), .CS(cs), .SCLK(pclk), .IN_RESET(rst),
    .MISO(miso1), .OUT_RECEIVE_DATA(out1));
  spi_fpga_slave #(.CPHA(0), .CPOL(1), .PACK_LENGTH(8),
                   .PACK_BIT_SEQUENCE_TRANSMIT(0), .PACK_BIT_SEQUENCE_RECEIVE(1)) u2 (
    .IN_TRANSMIT_DATA(txd), .MOSI(mosi), .CS(cs), .SCLK(~pclk), .IN_RESET(rst),
    .MISO(miso2), .OUT_RECEIVE_DATA(out2));
  spi_fpga_slave #(.CPHA(1), .CPOL(1), .PACK_LENGTH(8),
                   .PACK_BIT_SEQUENCE_TRANSMIT(1), .PACK_BIT_SEQUENCE_RECEIVE(1)) u3 (
    .IN_TRANSMIT_DATA(txd), .MOSI(mosi), .CS(cs), .SCLK(~pclk), .IN_RESET(rst),
    .MISO(miso3), .OUT_RECEIVE_DATA(out3));

  typedef struct {
    int         n;       // bits clocked while CS is low
    logic [15:0] bits;   // sent oldest first from bit n-1 down to bit 0
    logic [7:0] tx;
    int         chg_at;  // bit at which IN_TRANSMIT_DATA is changed (-1 = never)
    logic [7:0] chg_tx;
    logic [7:0] exp3;    // OUT_RECEIVE_DATA of the mode 3 MSB/MSB slave afterwards
    logic [7:0] exp0;    // OUT_RECEIVE_DATA of the mode 0 LSB/LSB slave afterwards
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic logic [7:0] get_out(input int k);
    case (k)
      0:       return out0;
      1:       return out1;
      2:       return out2;
      default: return out3;
    endcase
  endfunction

  function automatic logic get_miso(input int k);
    case (k)
      0:       return miso0;
      1:       return miso1;
      2:       return miso2;
      default: return miso3;
    endcase
  endfunction

  // Word formed from a time-ordered bit vector (t[0] first) under a given bit order.
  function automatic logic [7:0] word_of(input logic [7:0] t, input logic msb);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[msb ? 7 - i : i] = t[i];
    return w;
  endfunction

  // One bit period: MOSI held for the whole period, MISO read just before each slave's sample edge.
  task automatic clock_bit(input logic b, output logic [3:0] cap);
    mosi = b;
    #5;
    cap[0] = miso0;
    cap[2] = miso2;
    pclk = 1'b1;
    #5;
    cap[1] = miso1;
    cap[3] = miso3;
    pclk = 1'b0;
    #1;
  endtask

  task automatic xfer(input int n, input logic [15:0] bits, input logic [7:0] tx,
                      input int chg_at, input logic [7:0] chg_tx);
    logic [3:0] cap;
    logic [7:0] rd [4];
    logic [7:0] rx_t;
    logic [7:0] pkt_tx;
    logic       b;
    pkt_tx = tx;
    rx_t   = '0;
    txd = tx;
    #2;
    cs = 1'b0;
    #1;
    for (int k = 0; k < 4; k += 2)
      check($sformatf("first_bit_before_sclk[%0d]", k), {7'b0, get_miso(k)},
            {7'b0, tx[TX_MSB[k] ? 7 : 0]});
    #4;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) txd = chg_tx;
      if (i % 8 == 0) pkt_tx = txd;
      b = bits[n - 1 - i];
      clock_bit(b, cap);
      rx_t[i % 8] = b;
      for (int k = 0; k < 4; k++) rd[k][i % 8] = cap[k];
      if (i % 8 == 7) begin
        for (int k = 0; k < 4; k++) begin
          exp_out[k] = word_of(rx_t, RX_MSB[k]);
          check($sformatf("rx_word_before_cs_rise[%0d]", k), get_out(k), exp_out[k]);
          check($sformatf("miso_word_read[%0d]", k), word_of(rd[k], TX_MSB[k]), pkt_tx);
        end
      end
    end
    cs = 1'b1;
    #5;
    for (int k = 0; k < 4; k++)
      check($sformatf("rx_word_after_cs_rise[%0d]", k), get_out(k), exp_out[k]);
  endtask

  initial begin
    logic [3:0] cap;
    int         n;
    int         chg;

    vecs[0] = '{8,  16'h0060, 8'h81, -1, 8'h00, 8'h60, 8'h06};
    vecs[1] = '{8,  16'h003C, 8'hA5, -1, 8'h00, 8'h3C, 8'h3C};
    vecs[2] = '{5,  16'h0016, 8'h00, -1, 8'h00, 8'h3C, 8'h3C};
    vecs[3] = '{8,  16'h00F0, 8'h5A,  3, 8'hFF, 8'hF0, 8'h0F};
    vecs[4] = '{16, 16'h1234, 8'h9C, -1, 8'h00, 8'h34, 8'h2C};

    rst = 1'b1; cs = 1'b1; mosi = 1'b0; pclk = 1'b0; txd = 8'h00;
    for (int k = 0; k < 4; k++) exp_out[k] = 8'h00;
    #3;
    for (int k = 0; k < 4; k++)
      check($sformatf("reset_out[%0d]", k), get_out(k), 8'h00);
    check("reset_idle_miso3_z", {7'b0, (miso3 === 1'bz)}, 8'd1);
    rst = 1'b0;
    #5;

    for (int v = 0; v < 5; v++) begin
      xfer(vecs[v].n, vecs[v].bits, vecs[v].tx, vecs[v].chg_at, vecs[v].chg_tx);
      check($sformatf("vec%0d_out_mode3", v), out3, vecs[v].exp3);
      check($sformatf("vec%0d_out_mode0", v), out0, vecs[v].exp0);
    end

    // Idle: SCLK activity with CS high must not disturb anything.
    cs = 1'b1;
    for (int i = 0; i < 8; i++) clock_bit(1'b1, cap);
    check("idle_miso0_z", {7'b0, (miso0 === 1'bz)}, 8'd1);
    check("idle_miso1_z", {7'b0, (miso1 === 1'bz)}, 8'd1);
    check("idle_miso2_z", {7'b0, (miso2 === 1'bz)}, 8'd1);
    check("idle_miso3_z", {7'b0, (miso3 === 1'bz)}, 8'd1);
    check("idle_out_mode3", out3, 8'h34);
    check("idle_out_mode0", out0, 8'h2C);

    // Reset in the middle of a packet, CS still low.
    txd = 8'hE7;
    #2;
    cs = 1'b0;
    #5;
    for (int i = 0; i < 4; i++) clock_bit(i[0], cap);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_out[k] = 8'h00;
      check($sformatf("midreset_out[%0d]", k), get_out(k), 8'h00);
      check($sformatf("midreset_miso_low[%0d]", k), {7'b0, get_miso(k)}, 8'h00);
    end
    #2;
    rst = 1'b0;
    #2;
    cs = 1'b1;
    #5;
    xfer(8, 16'h0055, 8'hC3, -1, 8'h00);
    check("after_reset_out_mode3", out3, 8'h55);

    // Randomized windows: partial, single and multi-packet, with mid-packet TX changes.
    for (int r = 0; r < 40; r++) begin
      n   = int'($urandom_range(1, 16));
      chg = (n > 2) ? int'($urandom_range(1, n - 1)) : -1;
      if (chg % 8 == 0) chg = -1;
      xfer(n, 16'($urandom), 8'($urandom), chg, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
